// File: rtl/alarm_sequencer.sv
// alarm_sequencer: arm/disarm state machine for the alarm system.
// Times the exit delay, entry delay and (optionally) the siren period with an
// internal down-counter advanced by the upstream one-cycle tick.
// Optional feature macro: ALARM_SIREN_TIMEOUT_EN. When it is defined, the siren
// times out after SIREN_TIME ticks and the system falls back to ARMED.
// When it is undefined, ALARM holds until a disarm edge or reset.
module alarm_sequencer #(
  parameter int TIMER_W    = 8,
  parameter int EXIT_TIME  = 30,
  parameter int ENTRY_TIME = 15,
  parameter int SIREN_TIME = 120
) (
  input  logic               clock50,
  input  logic               Mr,
  input  logic               tick,
  input  logic               arm,
  input  logic               disarm,
  input  logic               sensor,
  output logic [2:0]         state,
  output logic               armed,
  output logic               beeper,
  output logic               siren,
  output logic               arm_fault,
  output logic [TIMER_W-1:0] remaining
);

  typedef enum logic [2:0] {
    S_DISARMED = 3'd0,
    S_EXIT     = 3'd1,
    S_ARMED    = 3'd2,
    S_ENTRY    = 3'd3,
    S_ALARM    = 3'd4
  } state_t;

  state_t               r_state;
  logic [TIMER_W-1:0]   r_timer;
  logic                 r_arm_q;
  logic                 r_disarm_q;
  logic                 r_armed;
  logic                 r_beeper;
  logic                 r_siren;
  logic                 r_arm_fault;

  state_t               w_state_nx;
  logic [TIMER_W-1:0]   w_timer_nx;
  logic                 w_fault_nx;
  logic                 w_arm_edge;
  logic                 w_disarm_edge;
  logic                 w_timer_one;

  // Unsigned decrement that saturates at zero.
  function automatic logic [TIMER_W-1:0] dec_sat(input logic [TIMER_W-1:0] t);
    return (t == '0) ? '0 : t - TIMER_W'(1);
  endfunction

  assign w_arm_edge    = arm & ~r_arm_q;
  assign w_disarm_edge = disarm & ~r_disarm_q;
  assign w_timer_one   = (r_timer == TIMER_W'(1));

  // Next-state and next-timer selection; disarm outranks everything else.
  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_fault_nx = 1'b0;
    if (w_disarm_edge) begin
      w_state_nx = S_DISARMED;
      w_timer_nx = '0;
    end else begin
      case (r_state)
        S_DISARMED: begin
          w_timer_nx = '0;
          if (w_arm_edge) begin
            if (sensor) begin
              w_fault_nx = 1'b1;
            end else begin
              w_state_nx = S_EXIT;
              w_timer_nx = TIMER_W'(EXIT_TIME);
            end
          end
        end
        S_EXIT: begin
          // Zone is ignored while the occupant is leaving.
          if (tick) begin
            if (w_timer_one) begin
              w_state_nx = S_ARMED;
              w_timer_nx = '0;
            end else begin
              w_timer_nx = dec_sat(r_timer);
            end
          end
        end
        S_ARMED: begin
          w_timer_nx = '0;
          if (sensor) begin
            w_state_nx = S_ENTRY;
            w_timer_nx = TIMER_W'(ENTRY_TIME);
          end
        end
        S_ENTRY: begin
          if (tick) begin
            if (w_timer_one) begin
              w_state_nx = S_ALARM;
`ifdef ALARM_SIREN_TIMEOUT_EN
              w_timer_nx = TIMER_W'(SIREN_TIME);
`else
              w_timer_nx = '0;
`endif
            end else begin
              w_timer_nx = dec_sat(r_timer);
            end
          end
        end
        S_ALARM: begin
`ifdef ALARM_SIREN_TIMEOUT_EN
          // Siren expiry re-arms; a still-tripped zone re-enters the entry delay next cycle.
          if (tick) begin
            if (w_timer_one) begin
              w_state_nx = S_ARMED;
              w_timer_nx = '0;
            end else begin
              w_timer_nx = dec_sat(r_timer);
            end
          end
`else
          w_timer_nx = '0;
`endif
        end
        default: begin
          // Codes 5..7 are unreachable; recover to a safe state.
          w_state_nx = S_DISARMED;
          w_timer_nx = '0;
        end
      endcase
    end
  end

  // State, timer, edge history and outputs, all registered from the next state.
  always_ff @(posedge clock50 or posedge Mr) begin
    if (Mr) begin
      r_state     <= S_DISARMED;
      r_timer     <= '0;
      r_arm_q     <= 1'b1;
      r_disarm_q  <= 1'b1;
      r_armed     <= 1'b0;
      r_beeper    <= 1'b0;
      r_siren     <= 1'b0;
      r_arm_fault <= 1'b0;
    end else begin
      r_state     <= w_state_nx;
      r_timer     <= w_timer_nx;
      r_arm_q     <= arm;
      r_disarm_q  <= disarm;
      r_armed     <= (w_state_nx == S_EXIT) || (w_state_nx == S_ARMED) ||
                     (w_state_nx == S_ENTRY) || (w_state_nx == S_ALARM);
      r_beeper    <= (w_state_nx == S_EXIT) || (w_state_nx == S_ENTRY);
      r_siren     <= (w_state_nx == S_ALARM);
      r_arm_fault <= w_fault_nx;
    end
  end

  assign state     = r_state;
  assign armed     = r_armed;
  assign beeper    = r_beeper;
  assign siren     = r_siren;
  assign arm_fault = r_arm_fault;
  assign remaining = r_timer;

endmodule
